// File: rtl/ghost_mode_sched_pkg.sv
// ---------------------------------------------------------------------------
// ghost_mode_sched_pkg
// Shared Pac-Man parameters: ghost mode encoding, scheduler state encoding,
// the scatter/chase phase table and the orange ghost's scatter corner.
// Imported by ghost_mode_sched and ghost_target_orange.
// ---------------------------------------------------------------------------
package ghost_mode_sched_pkg;

   typedef enum logic [1:0] {
      GM_SCATTER    = 2'd0,
      GM_CHASE      = 2'd1,
      GM_FRIGHTENED = 2'd2
   } ghost_mode_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_FRIGHT = 1'b1
   } sched_state_t;

   localparam int PHASE_W = 3;
   localparam int TIMER_W = 11;
   localparam int PIX_W   = 9;
   localparam int TILE_W  = 6;
   localparam int D2_W    = 12;

   // Last phase is chase forever; its timer never advances.
   localparam logic [PHASE_W-1:0] LAST_PHASE = 3'd7;

   // Orange ghost scatter corner (tile 0, 35).
   localparam logic [PIX_W-1:0] CORNER_X = 9'd0;
   localparam logic [PIX_W-1:0] CORNER_Y = 9'd280;

   // Orange chases only while at least 8 tiles away (squared distance).
   localparam logic [D2_W-1:0] CHASE_MIN_D2 = 12'd64;

   // Phase durations in frames. The last phase is unbounded; its entry is
   // never consulted because the timer holds there.
   function automatic logic [TIMER_W-1:0] phase_dur(input logic [PHASE_W-1:0] ph);
      logic [TIMER_W-1:0] dur;
      case (ph)
         3'd0, 3'd2:       dur = 11'd420;
         3'd1, 3'd3, 3'd5: dur = 11'd1200;
         3'd4, 3'd6:       dur = 11'd300;
         default:          dur = 11'd0;
      endcase
      return dur;
   endfunction

   // Even phases scatter, odd phases chase.
   function automatic ghost_mode_t phase_mode(input logic [PHASE_W-1:0] ph);
      return ph[0] ? GM_CHASE : GM_SCATTER;
   endfunction

endpackage

// File: rtl/ghost_mode_sched_target_orange.sv
// ---------------------------------------------------------------------------
// ghost_target_orange
// Registered target pixel for the orange ghost. In chase mode the ghost
// heads for Pac-Man while it is at least 8 tiles away (squared tile distance
// >= 64); otherwise, and in scatter/frightened modes, it heads for its
// corner.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   mode_i                    current ghost mode (ghost_mode_t encoding)
//   x_pac_i, y_pac_i          Pac-Man pixel position
//   x_orange_i, y_orange_i    orange ghost pixel position
//   x_target_o, y_target_o    target pixel, one cycle after the inputs
// ---------------------------------------------------------------------------
module ghost_target_orange
   import ghost_mode_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] mode_i,
   input  logic [8:0] x_pac_i,
   input  logic [8:0] y_pac_i,
   input  logic [8:0] x_orange_i,
   input  logic [8:0] y_orange_i,
   output logic [8:0] x_target_o,
   output logic [8:0] y_target_o
);

   logic [TILE_W-1:0] tx_pac, ty_pac, tx_or, ty_or;
   logic [TILE_W-1:0] dx, dy;
   logic [D2_W-1:0]   dx_w, dy_w, d2;
   logic [PIX_W-1:0]  x_target_d, y_target_d, x_target_q, y_target_q;
   logic              unused_lsbs;

   // Only whole tiles matter for distance; the orange pixel offset is unused.
   assign unused_lsbs = ^{x_orange_i[2:0], y_orange_i[2:0]};

   assign tx_pac = x_pac_i[8:3];
   assign ty_pac = y_pac_i[8:3];
   assign tx_or  = x_orange_i[8:3];
   assign ty_or  = y_orange_i[8:3];

   assign dx = (tx_pac >= tx_or) ? (tx_pac - tx_or) : (tx_or - tx_pac);
   assign dy = (ty_pac >= ty_or) ? (ty_pac - ty_or) : (ty_or - ty_pac);

   // Squared distance is kept to 12 bits; larger sums wrap.
   assign dx_w = {6'd0, dx};
   assign dy_w = {6'd0, dy};
   assign d2   = dx_w * dx_w + dy_w * dy_w;

   always_comb begin
      x_target_d = CORNER_X;
      y_target_d = CORNER_Y;
      if ((mode_i == GM_CHASE) && (d2 >= CHASE_MIN_D2)) begin
         x_target_d = x_pac_i;
         y_target_d = y_pac_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_target_q <= CORNER_X;
         y_target_q <= CORNER_Y;
      end else begin
         x_target_q <= x_target_d;
         y_target_q <= y_target_d;
      end
   end

   assign x_target_o = x_target_q;
   assign y_target_o = y_target_q;

endmodule

// File: rtl/ghost_mode_sched.sv
// ---------------------------------------------------------------------------
// ghost_mode_sched
// Ghost mode scheduler: walks the scatter/chase phase table on frame strobes,
// enters frightened mode on power pellets (freezing the phase), drives the
// frightened-sprite flash and computes the orange ghost's target.
// Ports:
//   vga_pix_clk, rst          pixel clock, synchronous active-high reset
//   frame_stb                 one pulse per frame
//   pellet_eaten              power pellet eaten (pulse)
//   pac_caught                Pac-Man caught / level restart (pulse)
//   x_pac, y_pac              Pac-Man pixel position
//   x_orange, y_orange        orange ghost pixel position
//   mode                      ghost_mode_t, registered
//   mode_change               one-cycle pulse telling ghosts to reverse
//   flash                     frightened sprite colour toggle
//   x_target, y_target        orange ghost target pixel, registered
// ---------------------------------------------------------------------------
module ghost_mode_sched
   import ghost_mode_sched_pkg::*;
#(
   parameter int FRIGHT_FRAMES = 360,
   parameter int FLASH_FRAMES  = 120,
   parameter int FLASH_PERIOD  = 15
) (
   input  logic       vga_pix_clk,
   input  logic       rst,
   input  logic       frame_stb,
   input  logic       pellet_eaten,
   input  logic       pac_caught,
   input  logic [8:0] x_pac,
   input  logic [8:0] y_pac,
   input  logic [8:0] x_orange,
   input  logic [8:0] y_orange,
   output logic [1:0] mode,
   output logic       mode_change,
   output logic       flash,
   output logic [8:0] x_target,
   output logic [8:0] y_target
);

   localparam int FRW = (FRIGHT_FRAMES < 2) ? 1 : $clog2(FRIGHT_FRAMES + 1);
   localparam int FPW = (FLASH_PERIOD < 2) ? 1 : $clog2(FLASH_PERIOD);

   localparam logic [FRW-1:0] FRIGHT_LOAD = FRW'(FRIGHT_FRAMES);
   localparam logic [FRW-1:0] FLASH_AT    = FRW'(FLASH_FRAMES);
   localparam logic [FRW-1:0] FR_ONE      = FRW'(1);
   localparam logic [FPW-1:0] FP_LAST     = FPW'(FLASH_PERIOD - 1);
   localparam logic [FPW-1:0] FP_ONE      = FPW'(1);
   // A fright shorter than the flash window flashes from the first frame.
   localparam bit             FLASH_AT_LOAD = (FRIGHT_FRAMES <= FLASH_FRAMES);

   sched_state_t         state_q, state_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [FRW-1:0]       fright_q, fright_d;
   logic [FPW-1:0]       fcnt_q, fcnt_d;
   logic                 flash_q, flash_d;
   logic                 mode_change_q, mode_change_d;
   ghost_mode_t          mode_q, mode_d;
   logic                 in_window;

   assign in_window = FLASH_AT_LOAD || (fright_q <= FLASH_AT);

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      timer_d       = timer_q;
      fright_d      = fright_q;
      fcnt_d        = fcnt_q;
      flash_d       = flash_q;
      mode_d        = mode_q;
      mode_change_d = 1'b0;

      if (pac_caught) begin
         state_d  = ST_RUN;
         phase_d  = '0;
         timer_d  = '0;
         fright_d = '0;
         fcnt_d   = '0;
         flash_d  = 1'b0;
         mode_d   = GM_SCATTER;
      end else if (pellet_eaten) begin
         // Only the first pellet reverses the ghosts; later ones just extend.
         if (state_q == ST_RUN) begin
            mode_change_d = 1'b1;
         end
         state_d  = ST_FRIGHT;
         fright_d = FRIGHT_LOAD;
         fcnt_d   = '0;
         flash_d  = FLASH_AT_LOAD;
         mode_d   = GM_FRIGHTENED;
      end else if (frame_stb) begin
         if (state_q == ST_RUN) begin
            if (phase_q != LAST_PHASE) begin
               if ((timer_q + 11'd1) == phase_dur(phase_q)) begin
                  phase_d       = phase_q + 3'd1;
                  timer_d       = '0;
                  mode_d        = phase_mode(phase_q + 3'd1);
                  mode_change_d = 1'b1;
               end else begin
                  timer_d = timer_q + 11'd1;
               end
            end
         end else begin
            fright_d = fright_q - FR_ONE;
            if (fright_q <= FR_ONE) begin
               // Resume the frozen phase silently.
               state_d  = ST_RUN;
               fright_d = '0;
               fcnt_d   = '0;
               flash_d  = 1'b0;
               mode_d   = phase_mode(phase_q);
            end else if (!FLASH_AT_LOAD && (fright_d == FLASH_AT)) begin
               flash_d = 1'b1;
               fcnt_d  = '0;
            end else if (in_window) begin
               if (fcnt_q == FP_LAST) begin
                  flash_d = ~flash_q;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FP_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         phase_q       <= '0;
         timer_q       <= '0;
         fright_q      <= '0;
         fcnt_q        <= '0;
         flash_q       <= 1'b0;
         mode_change_q <= 1'b0;
         mode_q        <= GM_SCATTER;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         timer_q       <= timer_d;
         fright_q      <= fright_d;
         fcnt_q        <= fcnt_d;
         flash_q       <= flash_d;
         mode_change_q <= mode_change_d;
         mode_q        <= mode_d;
      end
   end

   assign mode        = mode_q;
   assign mode_change = mode_change_q;
   assign flash       = flash_q;

   ghost_target_orange u_target (
      .clk_i      (vga_pix_clk),
      .rst_i      (rst),
      .mode_i     (mode_q),
      .x_pac_i    (x_pac),
      .y_pac_i    (y_pac),
      .x_orange_i (x_orange),
      .y_orange_i (y_orange),
      .x_target_o (x_target),
      .y_target_o (y_target)
   );

endmodule

// File: tb/tb_ghost_mode_sched.sv
`timescale 1ns/1ps
module tb_ghost_mode_sched;

   localparam int FRIGHT_FRAMES = 360;
   localparam int FLASH_FRAMES  = 120;
   localparam int FLASH_PERIOD  = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fs = 1'b0, pe = 1'b0, pc = 1'b0;
   logic [8:0] xp = 9'd0, yp = 9'd0, xo = 9'd0, yo = 9'd0;
   logic [1:0] mode;
   logic       mc, flash;
   logic [8:0] xt, yt;

   int  n_checks = 0;
   int  n_errs   = 0;
   int  pulses   = 0;
   bit  rand_pos = 1'b1;

   // Reference model state
   bit  m_fr  = 1'b0;
   int  m_ph  = 0;
   int  m_tm  = 0;
   int  m_frt = 0;

   always #5 clk = ~clk;

   ghost_mode_sched #(
      .FRIGHT_FRAMES (FRIGHT_FRAMES),
      .FLASH_FRAMES  (FLASH_FRAMES),
      .FLASH_PERIOD  (FLASH_PERIOD)
   ) dut (
      .vga_pix_clk  (clk),
      .rst          (rst),
      .frame_stb    (fs),
      .pellet_eaten (pe),
      .pac_caught   (pc),
      .x_pac        (xp),
      .y_pac        (yp),
      .x_orange     (xo),
      .y_orange     (yo),
      .mode         (mode),
      .mode_change  (mc),
      .flash        (flash),
      .x_target     (xt),
      .y_target     (yt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dur(input int p);
      case (p)
         0, 2:    return 420;
         1, 3, 5: return 1200;
         4, 6:    return 300;
         default: return 0;
      endcase
   endfunction

   function automatic int m_mode();
      if (m_fr) return 2;
      return (m_ph % 2 == 1) ? 1 : 0;
   endfunction

   function automatic int m_flash();
      if (!m_fr || m_frt > FLASH_FRAMES) return 0;
      return (((FLASH_FRAMES - m_frt) / FLASH_PERIOD) % 2 == 0) ? 1 : 0;
   endfunction

   task automatic new_pos();
      xp = 9'($urandom_range(0, 511));
      yp = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) begin
         xo = xp + 9'($urandom_range(0, 80));
         yo = yp + 9'($urandom_range(0, 80));
      end else begin
         xo = 9'($urandom_range(0, 511));
         yo = 9'($urandom_range(0, 511));
      end
   endtask

   // One clock: apply inputs, advance the model, compare all outputs.
   task automatic step(input bit r, input bit f, input bit p, input bit c);
      int pre_mode, exp_mc, exp_xt, exp_yt, dx, dy, d2;
      if (rand_pos) new_pos();
      rst = r; fs = f; pe = p; pc = c;
      pre_mode = m_mode();
      dx = int'(xp) / 8 - int'(xo) / 8;
      dy = int'(yp) / 8 - int'(yo) / 8;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      d2 = (dx * dx + dy * dy) % 4096;
      if (!r && pre_mode == 1 && d2 >= 64) begin
         exp_xt = int'(xp); exp_yt = int'(yp);
      end else begin
         exp_xt = 0; exp_yt = 280;
      end
      exp_mc = 0;
      if (r || c) begin
         m_fr = 1'b0; m_ph = 0; m_tm = 0; m_frt = 0;
      end else if (p) begin
         if (!m_fr) exp_mc = 1;
         m_fr = 1'b1; m_frt = FRIGHT_FRAMES;
      end else if (f) begin
         if (m_fr) begin
            m_frt--;
            if (m_frt == 0) m_fr = 1'b0;
         end else if (m_ph != 7) begin
            m_tm++;
            if (m_tm == dur(m_ph)) begin
               m_ph++; m_tm = 0; exp_mc = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (mc) pulses++;
      chk("mode", int'(mode), m_mode());
      chk("mode_change", int'(mc), exp_mc);
      chk("flash", int'(flash), m_flash());
      chk("x_target", int'(xt), exp_xt);
      chk("y_target", int'(yt), exp_yt);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      pulses = 0;
   endtask

   initial begin
      // Reset values
      do_reset();
      chk("rst_mode", int'(mode), 0);
      chk("rst_flash", int'(flash), 0);
      chk("rst_mc", int'(mc), 0);

      // Scatter -> chase -> scatter
      frames(420);
      chk("p1_chase", int'(mode), 1);
      chk("p1_pulses", pulses, 1);
      frames(1200);
      chk("p2_scatter", int'(mode), 0);
      chk("p2_pulses", pulses, 2);

      // Pellet mid-chase freezes and resumes the phase timer
      do_reset();
      frames(920);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("pel_mode", int'(mode), 2);
      chk("pel_pulses", pulses, 2);
      frames(360);
      chk("resume_chase", int'(mode), 1);
      chk("resume_pulses", pulses, 2);
      frames(699);
      chk("chase_699", int'(mode), 1);
      frames(1);
      chk("chase_end", int'(mode), 0);

      // Second pellet reloads without a pulse
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      frames(300);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      frames(359);
      chk("reload_mode", int'(mode), 2);
      chk("reload_pulses", pulses, 1);
      frames(1);
      chk("reload_exit", int'(mode), 0);

      // Flash window
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      frames(239);
      chk("flash_121", int'(flash), 0);
      frames(1);
      chk("flash_120", int'(flash), 1);
      frames(14);
      chk("flash_106", int'(flash), 1);
      frames(1);
      chk("flash_105", int'(flash), 0);
      frames(15);
      chk("flash_90", int'(flash), 1);

      // pac_caught beats pellet and frame in P3
      do_reset();
      frames(2090);
      chk("p3_chase", int'(mode), 1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("caught_mode", int'(mode), 0);
      chk("caught_mc", int'(mc), 0);
      frames(419);
      chk("caught_p0_419", int'(mode), 0);
      frames(1);
      chk("caught_p0_end", int'(mode), 1);

      // Orange target near/far in chase
      do_reset();
      frames(420);
      rand_pos = 1'b0;
      xp = 9'd80; yp = 9'd80; xo = 9'd80; yo = 9'd200;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("far_xt", int'(xt), 80);
      chk("far_yt", int'(yt), 80);
      xo = 9'd96; yo = 9'd96;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("near_xt", int'(xt), 0);
      chk("near_yt", int'(yt), 280);
      rand_pos = 1'b1;

      // Final phase holds in chase forever
      do_reset();
      frames(5040);
      chk("p7_chase", int'(mode), 1);
      chk("p7_pulses", pulses, 7);
      frames(1500);
      chk("p7_hold", int'(mode), 1);
      chk("p7_hold_pulses", pulses, 7);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 12000; i++) begin
         step(($urandom_range(0, 5999) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 499) == 0),
              ($urandom_range(0, 3999) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/ghost_mode_sched.md
GHOST_MODE_SCHED -- requirements
Module: ghost_mode_sched

Interface
REQ-001 Parameter FRIGHT_FRAMES, default 360, frightened duration in frames.
REQ-002 Parameter FLASH_FRAMES, default 120, final frightened window in which flash toggles.
REQ-003 Parameter FLASH_PERIOD, default 15, frames per flash half-period.
REQ-004 vga_pix_clk  in  1  pixel clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 frame_stb  in  1  one-cycle pulse per frame (60 Hz).
REQ-007 pellet_eaten  in  1  one-cycle pulse when Pac-Man eats a power pellet.
REQ-008 pac_caught  in  1  one-cycle pulse when Pac-Man is caught or the level restarts.
REQ-009 x_pac, y_pac  in  9 each  Pac-Man pixel position.
REQ-010 x_orange, y_orange  in  9 each  orange ghost pixel position.
REQ-011 mode  out  2  current ghost_mode_t: SCATTER, CHASE or FRIGHTENED.
REQ-012 mode_change  out  1  one-cycle pulse; ghosts reverse direction.
REQ-013 flash  out  1  frightened-sprite colour toggle.
REQ-014 x_target, y_target  out  9 each  orange ghost target pixel, registered.

Function
REQ-015 Phase table in frames: P0 SCATTER 420, P1 CHASE 1200, P2 SCATTER 420, P3 CHASE 1200, P4 SCATTER 300, P5 CHASE 1200, P6 SCATTER 300, P7 CHASE unbounded.
REQ-016 States: RUN (mode from phase) and FRIGHT; phase index is 3 bits; phase timer is 11 bits.
REQ-017 In RUN, the phase timer SHALL increment on each frame_stb; on the frame_stb where timer+1 equals the phase duration, phase SHALL advance, the timer SHALL clear, and mode_change SHALL pulse on the next cycle.
REQ-018 In P7 the timer SHALL hold, and no further transition occurs.
REQ-019 pellet_eaten in RUN SHALL enter FRIGHT, load the fright timer with FRIGHT_FRAMES, freeze the phase timer and phase, and pulse mode_change.
REQ-020 pellet_eaten in FRIGHT SHALL reload the fright timer without pulsing mode_change.
REQ-021 In FRIGHT, the fright timer SHALL decrement on each frame_stb; on reaching 0, the block SHALL return to RUN at the frozen phase and timer with no mode_change pulse.
REQ-022 flash SHALL be 0 outside FRIGHT and while fright timer > FLASH_FRAMES; below that it toggles every FLASH_PERIOD frames, starting at 1.
REQ-023 pac_caught SHALL force RUN, P0, timers 0, flash 0, mode_change 0; it has priority over pellet_eaten and frame_stb in the same cycle.
REQ-024 If pellet_eaten and frame_stb coincide, the pellet action SHALL apply and that frame SHALL not be counted.
REQ-025 Target logic: tile = pixel/8; dx, dy = absolute tile differences (6 bits); d2 = dx*dx + dy*dy (12 bits, unsigned).
REQ-026 In CHASE with d2 >= 64, the target SHALL be (x_pac, y_pac); otherwise, and in SCATTER and FRIGHTENED, the target SHALL be the corner (0, 8*35).
REQ-027 x_target/y_target SHALL reflect inputs and mode with 1-cycle latency.
REQ-028 mode SHALL be registered and SHALL change on the same edge as the state/phase update.

Reset
REQ-029 rst SHALL set the state to RUN, phase to 0, both timers to 0, mode to SCATTER, and mode_change and flash to 0.
REQ-030 rst SHALL set x_target/y_target to (0, 280).
REQ-031 rst mid-FRIGHT SHALL discard the frozen phase, with no mode_change pulse.

Structure
REQ-032 ghost_mode_t and the phase-duration/mode table SHALL live in the shared params::pacman package.
REQ-033 Target computation SHALL be a sub-module ghost_target_orange, instantiated once.

Verification
REQ-034 Reset, then 420 frame_stb -> mode goes SCATTER->CHASE with one mode_change pulse; 1200 more -> SCATTER.
REQ-035 Pellet at P1 timer 500 -> FRIGHTENED plus pulse; 360 frames later -> CHASE at timer 500 with no pulse; CHASE ends 700 frames later.
REQ-036 Pellet, then a second pellet after 300 frames -> still FRIGHTENED 359 frames after the second pellet, with only one mode_change pulse in total.
REQ-037 FRIGHT: flash 0 at fright timer 121, 1 at 120, then toggles every 15 frames.
REQ-038 pac_caught plus pellet_eaten in the same cycle during P3 -> SCATTER, P0, no pulse.
REQ-039 CHASE with pac at (80,80) and orange at (80,200), d2=225 -> target (80,80); with orange at (96,96), d2=8 -> target (0,280).
